pipe_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the ALU's 32-bit carry-lookahead adder. It splits a WIDTH-bit operation into STAGES equal chunks and computes one chunk per pipeline stage, registering the carry between stages. It adds a subtract mode, carry/overflow/zero flags and a valid/ready handshake on both sides with full backpressure. It sits between the operand-fetch logic and the ALU result mux.

---
 rtl/pipe_add_sub.sv | 142 ++++++++++++++
 tb/tb_pipe_add_sub.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : pipe_add_sub
// Description : Pipelined two's-complement adder/subtractor. One CW-bit chunk
//               is computed per stage, with an elastic valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int c_CW   = WIDTH / STAGES;
    localparam int c_LAST = STAGES - 1;

    logic [WIDTH-1:0]  w_b_eff;
    logic [STAGES:0]   w_ready;

    // What each stage would load this cycle: either the input port or the
    // previous stage's registers.
    logic [STAGES-1:0] w_src_valid;
    logic [STAGES-1:0] w_src_c;
    logic [STAGES-1:0] w_cout;
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_src_sum [STAGES];
    logic [WIDTH-1:0]  w_new_sum [STAGES];

    logic [STAGES-1:0] r_valid_q, w_valid_d;
    logic [STAGES-1:0] r_carry_q, w_carry_d;
    logic [WIDTH-1:0]  r_sum_q [STAGES];
    logic [WIDTH-1:0]  w_sum_d [STAGES];
    logic [WIDTH-1:0]  r_opa_q [STAGES];
    logic [WIDTH-1:0]  w_opa_d [STAGES];
    logic [WIDTH-1:0]  r_opb_q [STAGES];
    logic [WIDTH-1:0]  w_opb_d [STAGES];
    logic              r_ovf_q, w_ovf_d;
    logic              r_zero_q, w_zero_d;

    assign w_b_eff = sub ? ~b : b;

    always_comb begin
        w_ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_ready[i] = !r_valid_q[i] || w_ready[i+1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [c_CW:0] w_chunk;

        if (gi == 0) begin : g_head
            assign w_src_valid[gi] = in_valid;
            assign w_src_a[gi]     = a;
            assign w_src_b[gi]     = w_b_eff;
            assign w_src_sum[gi]   = '0;
            assign w_src_c[gi]     = sub;
        end else begin : g_body
            assign w_src_valid[gi] = r_valid_q[gi-1];
            assign w_src_a[gi]     = r_opa_q[gi-1];
            assign w_src_b[gi]     = r_opb_q[gi-1];
            assign w_src_sum[gi]   = r_sum_q[gi-1];
            assign w_src_c[gi]     = r_carry_q[gi-1];
        end

        assign w_chunk = {1'b0, w_src_a[gi][gi*c_CW +: c_CW]}
                       + {1'b0, w_src_b[gi][gi*c_CW +: c_CW]}
                       + {{c_CW{1'b0}}, w_src_c[gi]};
        assign w_cout[gi] = w_chunk[c_CW];
        // Chunk gi of the incoming partial sum is still zero, so OR inserts it.
        assign w_new_sum[gi] = w_src_sum[gi] | (WIDTH'(w_chunk[c_CW-1:0]) << (gi * c_CW));
    end

    always_comb begin
        w_ovf_d  = r_ovf_q;
        w_zero_d = r_zero_q;
        for (int i = 0; i < STAGES; i++) begin
            w_valid_d[i] = w_ready[i] ? w_src_valid[i] : r_valid_q[i];
            w_carry_d[i] = r_carry_q[i];
            w_sum_d[i]   = r_sum_q[i];
            w_opa_d[i]   = r_opa_q[i];
            w_opb_d[i]   = r_opb_q[i];
            if (w_ready[i] && w_src_valid[i]) begin
                w_carry_d[i] = w_cout[i];
                w_sum_d[i]   = w_new_sum[i];
                w_opa_d[i]   = w_src_a[i];
                w_opb_d[i]   = w_src_b[i];
            end
        end
        if (w_ready[c_LAST] && w_src_valid[c_LAST]) begin
            w_ovf_d  = (w_src_a[c_LAST][WIDTH-1] == w_src_b[c_LAST][WIDTH-1]) &&
                       (w_new_sum[c_LAST][WIDTH-1] != w_src_a[c_LAST][WIDTH-1]);
            w_zero_d = (w_new_sum[c_LAST] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= '0;
            r_carry_q <= '0;
            r_ovf_q   <= 1'b0;
            r_zero_q  <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                r_sum_q[i] <= '0;
                r_opa_q[i] <= '0;
                r_opb_q[i] <= '0;
            end
        end else begin
            r_valid_q <= w_valid_d;
            r_carry_q <= w_carry_d;
            r_ovf_q   <= w_ovf_d;
            r_zero_q  <= w_zero_d;
            for (int i = 0; i < STAGES; i++) begin
                r_sum_q[i] <= w_sum_d[i];
                r_opa_q[i] <= w_opa_d[i];
                r_opb_q[i] <= w_opb_d[i];
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid_q[c_LAST];
    assign sum       = r_sum_q[c_LAST];
    assign carry     = r_carry_q[c_LAST];
    assign overflow  = r_ovf_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_add_sub
// Description : Self-checking bench for pipe_add_sub in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_add_sub;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;

    logic        rdy_a, ov_a, c_a, of_a, z_a;
    logic [31:0] s_a;
    logic        rdy_b, ov_b, c_b, of_b, z_b;
    logic [31:0] s_b;
    logic        rdy_c, ov_c, c_c, of_c, z_c;
    logic [15:0] s_c;

    pipe_add_sub #(.WIDTH(32), .STAGES(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .a(a), .b(b), .sub(sub),
        .out_valid(ov_a), .out_ready(out_ready), .sum(s_a), .carry(c_a), .overflow(of_a), .zero(z_a));
    pipe_add_sub #(.WIDTH(32), .STAGES(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .a(a), .b(b), .sub(sub),
        .out_valid(ov_b), .out_ready(out_ready), .sum(s_b), .carry(c_b), .overflow(of_b), .zero(z_b));
    pipe_add_sub #(.WIDTH(16), .STAGES(2)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .a(a[15:0]), .b(b[15:0]), .sub(sub),
        .out_valid(ov_c), .out_ready(out_ready), .sum(s_c), .carry(c_c), .overflow(of_c), .zero(z_c));

    int cfg = 0, W = 32, S = 4;
    int pass_cnt = 0, total_cnt = 0;

    logic        obs_in_ready, obs_out_valid, obs_carry, obs_ovf, obs_zero;
    logic [31:0] obs_sum;

    always_comb begin
        obs_in_ready  = rdy_a; obs_out_valid = ov_a; obs_sum = s_a;
        obs_carry     = c_a;   obs_ovf       = of_a; obs_zero = z_a;
        case (cfg)
            1: begin
                obs_in_ready = rdy_b; obs_out_valid = ov_b; obs_sum = s_b;
                obs_carry    = c_b;   obs_ovf       = of_b; obs_zero = z_b;
            end
            2: begin
                obs_in_ready = rdy_c; obs_out_valid = ov_c; obs_sum = {16'h0, s_c};
                obs_carry    = c_c;   obs_ovf       = of_c; obs_zero = z_c;
            end
            default: ;
        endcase
    end

    function automatic logic [34:0] obs_res();
        return {obs_sum, obs_carry, obs_ovf, obs_zero};
    endfunction

    // Reference: unsigned and signed arithmetic on W-bit values.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint full, half, m, ux, uy, sx, sy, r;
        logic [31:0] res;
        logic c, o;
        full = longint'(1) << W;
        half = full >> 1;
        m    = full - 1;
        ux   = longint'(x) & m;
        uy   = longint'(y) & m;
        sx   = (ux >= half) ? ux - full : ux;
        sy   = (uy >= half) ? uy - full : uy;
        r    = s ? sx - sy : sx + sy;
        o    = (r < -half) || (r >= half);
        if (s) begin
            res = 32'((ux - uy) & m);
            c   = (ux >= uy);
        end else begin
            res = 32'((ux + uy) & m);
            c   = ((ux + uy) >= full);
        end
        return {res, c, o, (res == 32'd0)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++;
        if ({obs_out_valid, obs_res()} !== 36'h0)
            $display("FAIL cfg%0d reset_outputs: got %h expected 0", cfg, {obs_out_valid, obs_res()});
        else pass_cnt++;
        total_cnt++;
        if (obs_in_ready !== 1'b1)
            $display("FAIL cfg%0d reset_in_ready: got %b expected 1", cfg, obs_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] ta [11] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF, 32'd5, 32'd7, 32'h80000000,
                                 32'h00007FFF, 32'h000000FF, 32'h0000FFFF, 32'd0, 32'h00008000};
        logic [31:0] tb_ [11] = '{32'h1, 32'h1, 32'h1, 32'd7, 32'd5, 32'h1,
                                  32'h1, 32'h1, 32'h0000FFFF, 32'd0, 32'h1};
        logic        ts [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [34:0] exp;
        int lat;
        for (int k = 0; k < 11; k++) begin
            exp = model(ta[k], tb_[k], ts[k]);
            @(negedge clk);
            in_valid = 1'b1; a = ta[k]; b = tb_[k]; sub = ts[k]; out_ready = 1'b1;
            #1;
            total_cnt++;
            if (obs_in_ready !== 1'b1)
                $display("FAIL cfg%0d dir%0d_in_ready: got %b expected 1", cfg, k, obs_in_ready);
            else pass_cnt++;
            @(negedge clk);
            in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
            lat = 1;
            #1;
            while (!obs_out_valid && lat < S + 4) begin
                @(negedge clk); #1; lat++;
            end
            total_cnt++;
            if (!obs_out_valid || lat != S)
                $display("FAIL cfg%0d dir%0d_latency: got %0d (valid %b) expected %0d", cfg, k, lat, obs_out_valid, S);
            else pass_cnt++;
            total_cnt++;
            if (obs_res() !== exp)
                $display("FAIL cfg%0d dir%0d_result: got %h expected %h", cfg, k, obs_res(), exp);
            else pass_cnt++;
            @(negedge clk); #1;
            total_cnt++;
            if (obs_out_valid !== 1'b0)
                $display("FAIL cfg%0d dir%0d_no_dup: got valid %b expected 0", cfg, k, obs_out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        logic [34:0] q[$];
        logic [34:0] held, exp;
        logic [31:0] na, nb;
        logic        ns, stall;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
        na = $urandom; nb = $urandom; ns = 1'($urandom);
        while ((got < 16 || sent < 16) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                total_cnt++;
                if (!obs_out_valid || obs_res() !== held)
                    $display("FAIL cfg%0d stream_stall_hold: got %b/%h expected 1/%h", cfg, obs_out_valid, obs_res(), held);
                else pass_cnt++;
            end
            in_valid = (sent < 16); a = na; b = nb; sub = ns; out_ready = 1'($urandom);
            #1;
            total_cnt++;
            if (obs_in_ready !== ((q.size() < S) || out_ready))
                $display("FAIL cfg%0d stream_in_ready: got %b expected %b (pending %0d)", cfg, obs_in_ready,
                         ((q.size() < S) || out_ready), q.size());
            else pass_cnt++;
            if (obs_out_valid && out_ready) begin
                total_cnt++;
                if (q.size() == 0)
                    $display("FAIL cfg%0d stream_extra_beat: got %h expected none", cfg, obs_res());
                else begin
                    exp = q.pop_front();
                    if (obs_res() !== exp)
                        $display("FAIL cfg%0d stream_result%0d: got %h expected %h", cfg, got, obs_res(), exp);
                    else pass_cnt++;
                end
                got++;
            end
            stall = obs_out_valid && !out_ready;
            held  = obs_res();
            if (in_valid && obs_in_ready) begin
                q.push_back(model(na, nb, ns));
                sent++;
                na = $urandom; nb = $urandom; ns = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got != 16 || sent != 16 || q.size() != 0)
            $display("FAIL cfg%0d stream_count: got %0d out/%0d in/%0d left expected 16/16/0", cfg, got, sent, q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] ba [6], bb [6];
        logic        bs [6];
        logic [34:0] exp;
        int idx, got, cyc;
        for (int k = 0; k < 6; k++) begin
            ba[k] = $urandom; bb[k] = $urandom; bs[k] = 1'($urandom);
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = (idx < 6);
            if (idx < 6) begin a = ba[idx]; b = bb[idx]; sub = bs[idx]; end
            #1;
            if (in_valid && obs_in_ready) idx++;
        end
        total_cnt++;
        if (idx != S)
            $display("FAIL cfg%0d bp_accepted: got %0d expected %0d", cfg, idx, S);
        else pass_cnt++;
        total_cnt++;
        if (obs_in_ready !== 1'b0)
            $display("FAIL cfg%0d bp_in_ready_full: got %b expected 0", cfg, obs_in_ready);
        else pass_cnt++;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 6);
            if (idx < 6) begin a = ba[idx]; b = bb[idx]; sub = bs[idx]; end
            #1;
            if (cyc < S) begin
                total_cnt++;
                if (obs_out_valid !== 1'b1)
                    $display("FAIL cfg%0d bp_drain_consecutive%0d: got valid %b expected 1", cfg, cyc, obs_out_valid);
                else pass_cnt++;
            end
            if (obs_out_valid) begin
                exp = model(ba[got], bb[got], bs[got]);
                total_cnt++;
                if (obs_res() !== exp)
                    $display("FAIL cfg%0d bp_result%0d: got %h expected %h", cfg, got, obs_res(), exp);
                else pass_cnt++;
                got++;
            end
            if (in_valid && obs_in_ready) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got != 6)
            $display("FAIL cfg%0d bp_count: got %0d expected 6", cfg, got);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        logic seen;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; a = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total_cnt++;
        if ({obs_out_valid, obs_res()} !== 36'h0)
            $display("FAIL cfg%0d midrst_outputs: got %h expected 0", cfg, {obs_out_valid, obs_res()});
        else pass_cnt++;
        total_cnt++;
        if (obs_in_ready !== 1'b1)
            $display("FAIL cfg%0d midrst_in_ready: got %b expected 1", cfg, obs_in_ready);
        else pass_cnt++;
        seen = 1'b0;
        for (int k = 0; k < 2 * S + 4; k++) begin
            @(negedge clk); #1;
            if (obs_out_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0)
            $display("FAIL cfg%0d midrst_stale_beat: got valid %b expected 0", cfg, seen);
        else pass_cnt++;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            cfg = c;
            W   = (c == 2) ? 16 : 32;
            S   = (c == 0) ? 4 : ((c == 1) ? 1 : 2);
            test_reset();
            test_directed();
            test_stream();
            test_backpressure();
            test_reset_midflight();
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
